stream_fifo_wm: RTL and testbench

Parametrised valid/ready stream FIFO, the successor to the current stream FIFO. It adds arbitrary (non-power-of-two) depth, an occupancy count and programmable almost-full/almost-empty watermarks. It also adds an optional same-cycle bypass when the FIFO is empty. It sits between MMU pipeline stages (PTW request/response queues, TLB refill buffers), where producers need early back-pressure hints.

---
 rtl/stream_fifo_pkg.sv | 18 +
 rtl/stream_fifo_mem.sv | 28 ++
 rtl/stream_fifo_wm.sv | 112 +++++++++++
 tb/tb_stream_fifo_wm.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared helpers for the stream FIFO family: pointer/count widths and pointer wrap.

package stream_fifo_pkg;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-two depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Depth x WordWidth register array, one write port and one asynchronous read port.

module stream_fifo_mem
    import stream_fifo_pkg::*;
#(
    parameter int unsigned Depth     = 8,
    parameter int unsigned WordWidth = 64
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [ptr_w(Depth)-1:0]   waddr_i,
    input  logic [WordWidth-1:0]      wdata_i,
    input  logic [ptr_w(Depth)-1:0]   raddr_i,
    output logic [WordWidth-1:0]      rdata_o
);

    logic [WordWidth-1:0] mem_q [Depth];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo_wm.sv
// Valid/ready stream FIFO with occupancy count and almost-full/almost-empty watermarks.
// Optional same-cycle empty bypass when STREAM_FIFO_WM_BYPASS_EN is defined.

module stream_fifo_wm
    import stream_fifo_pkg::*;
#(
    parameter int unsigned Depth     = 8,
    parameter int unsigned WordWidth = 64,
    parameter int unsigned AfThresh  = Depth - 1,
    parameter int unsigned AeThresh  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     enq_vld_i,
    input  logic [WordWidth-1:0]     enq_payload_i,
    output logic                     enq_rdy_o,
    output logic                     deq_vld_o,
    output logic [WordWidth-1:0]     deq_payload_o,
    input  logic                     deq_rdy_i,
    output logic [cnt_w(Depth)-1:0]  count_o,
    output logic                     almost_full_o,
    output logic                     almost_empty_o
);

    localparam int unsigned PtrW = ptr_w(Depth);
    localparam int unsigned CntW = cnt_w(Depth);

    localparam logic [CntW-1:0] DepthC = CntW'(Depth);
    localparam logic [CntW-1:0] AfC    = CntW'(AfThresh);
    localparam logic [CntW-1:0] AeC    = CntW'(AeThresh);

    if (Depth < 2) begin : gen_bad_depth
        $error("stream_fifo_wm: Depth must be >= 2");
    end
    if (AfThresh < 1 || AfThresh > Depth) begin : gen_bad_af
        $error("stream_fifo_wm: AfThresh must be in 1..Depth");
    end
    if (AeThresh > Depth - 1) begin : gen_bad_ae
        $error("stream_fifo_wm: AeThresh must be in 0..Depth-1");
    end

    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [WordWidth-1:0] mem_rdata;
    logic                 enq_fire, deq_fire, pass, do_write, do_pop;

    assign enq_rdy_o = (count_q != DepthC);

`ifdef STREAM_FIFO_WM_BYPASS_EN
    logic bypass;
    assign bypass        = (count_q == '0) && !flush_i;
    assign deq_vld_o     = bypass ? enq_vld_i : (count_q != '0);
    assign deq_payload_o = bypass ? enq_payload_i : mem_rdata;
    assign pass          = bypass && enq_vld_i && deq_rdy_i;
`else
    assign deq_vld_o     = (count_q != '0);
    assign deq_payload_o = mem_rdata;
    assign pass          = 1'b0;
`endif

    assign enq_fire = enq_vld_i && enq_rdy_o;
    assign deq_fire = deq_vld_o && deq_rdy_i;
    // A passed-through beat touches neither storage nor state.
    assign do_write = enq_fire && !pass;
    assign do_pop   = deq_fire && !pass;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_write) wptr_d = PtrW'(ptr_inc(32'(wptr_q), Depth));
            if (do_pop)   rptr_d = PtrW'(ptr_inc(32'(rptr_q), Depth));
            if (do_write && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_write) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    stream_fifo_mem #(
        .Depth    (Depth),
        .WordWidth(WordWidth)
    ) u_mem (
        .clk    (clk),
        .we_i   (do_write && !flush_i),
        .waddr_i(wptr_q),
        .wdata_i(enq_payload_i),
        .raddr_i(rptr_q),
        .rdata_o(mem_rdata)
    );

    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= AfC);
    assign almost_empty_o = (count_q <= AeC);

endmodule

// File: tb/tb_stream_fifo_wm.sv
// Directed self-checking bench for stream_fifo_wm (Depth=5, AfThresh=4, AeThresh=1).

module tb_stream_fifo_wm;

    localparam int unsigned Depth = 5;
    localparam int unsigned WW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          enq_vld_i;
    logic [WW-1:0] enq_payload_i;
    logic          enq_rdy_o;
    logic          deq_vld_o;
    logic [WW-1:0] deq_payload_o;
    logic          deq_rdy_i;
    logic [2:0]    count_o;
    logic          almost_full_o;
    logic          almost_empty_o;

    int checks = 0;
    int errors = 0;

    stream_fifo_wm #(
        .Depth    (Depth),
        .WordWidth(WW),
        .AfThresh (4),
        .AeThresh (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .enq_vld_i     (enq_vld_i),
        .enq_payload_i (enq_payload_i),
        .enq_rdy_o     (enq_rdy_o),
        .deq_vld_o     (deq_vld_o),
        .deq_payload_o (deq_payload_o),
        .deq_rdy_i     (deq_rdy_i),
        .count_o       (count_o),
        .almost_full_o (almost_full_o),
        .almost_empty_o(almost_empty_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n words base, base+1, ... with the consumer stalled.
    task automatic fill(input logic [WW-1:0] base, input int n);
        deq_rdy_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            enq_vld_i     = 1'b1;
            enq_payload_i = base + WW'(i);
            tick();
        end
        enq_vld_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks += 5;
        if (enq_rdy_o !== 1'b1) begin errors++; $display("FAIL rst_enq_rdy: got %b expected 1", enq_rdy_o); end
        if (deq_vld_o !== 1'b0) begin errors++; $display("FAIL rst_deq_vld: got %b expected 0", deq_vld_o); end
        if (count_o !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count_o); end
        if (almost_full_o !== 1'b0) begin errors++; $display("FAIL rst_af: got %b expected 0", almost_full_o); end
        if (almost_empty_o !== 1'b1) begin errors++; $display("FAIL rst_ae: got %b expected 1", almost_empty_o); end
    endtask

    task automatic test_fill_drain();
        deq_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enq_vld_i     = 1'b1;
            enq_payload_i = 8'hA0 + 8'(i);
            #1;
            checks++;
            if (enq_rdy_o !== 1'b1) begin errors++; $display("FAIL fill_rdy[%0d]: got %b expected 1", i, enq_rdy_o); end
            tick();
            checks += 3;
            if (count_o !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count_o, i + 1); end
            if (almost_full_o !== (i + 1 >= 4)) begin errors++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full_o, (i + 1 >= 4)); end
            if (almost_empty_o !== (i + 1 <= 1)) begin errors++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, almost_empty_o, (i + 1 <= 1)); end
        end
        enq_payload_i = 8'hAF;
        #1;
        checks++;
        if (enq_rdy_o !== 1'b0) begin errors++; $display("FAIL full_rdy: got %b expected 0", enq_rdy_o); end
        tick();
        checks++;
        if (count_o !== 3'd5) begin errors++; $display("FAIL full_hold: got %0d expected 5", count_o); end
        enq_vld_i = 1'b0;
        deq_rdy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks += 2;
            if (deq_vld_o !== 1'b1) begin errors++; $display("FAIL drain_vld[%0d]: got %b expected 1", i, deq_vld_o); end
            if (deq_payload_o !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, deq_payload_o, 8'hA0 + 8'(i)); end
            tick();
            checks++;
            if (count_o !== 3'(4 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count_o, 4 - i); end
        end
        checks++;
        if (deq_vld_o !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", deq_vld_o); end
        deq_rdy_i = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [WW-1:0] exp_q [5] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC0};
        fill(8'hB0, 5);
        enq_vld_i     = 1'b1;
        enq_payload_i = 8'hC0;
        deq_rdy_i     = 1'b1;
        #1;
        checks += 2;
        if (enq_rdy_o !== 1'b0) begin errors++; $display("FAIL fullpop_rdy: got %b expected 0", enq_rdy_o); end
        if (deq_payload_o !== 8'hB0) begin errors++; $display("FAIL fullpop_head: got %0h expected b0", deq_payload_o); end
        tick();
        deq_rdy_i = 1'b0;
        #1;
        checks += 2;
        if (count_o !== 3'd4) begin errors++; $display("FAIL fullpop_count: got %0d expected 4", count_o); end
        if (enq_rdy_o !== 1'b1) begin errors++; $display("FAIL fullpop_rdy2: got %b expected 1", enq_rdy_o); end
        tick();
        enq_vld_i = 1'b0;
        checks++;
        if (count_o !== 3'd5) begin errors++; $display("FAIL fullpop_refill: got %0d expected 5", count_o); end
        deq_rdy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (deq_payload_o !== exp_q[i]) begin errors++; $display("FAIL fullpop_order[%0d]: got %0h expected %0h", i, deq_payload_o, exp_q[i]); end
            tick();
        end
        deq_rdy_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        fill(8'hD0, 3);
        enq_vld_i = 1'b1;
        deq_rdy_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq_payload_i = 8'hD3 + 8'(i);
            #1;
            checks++;
            if (deq_payload_o !== 8'hD0 + 8'(i)) begin errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, deq_payload_o, 8'hD0 + 8'(i)); end
            tick();
            checks++;
            if (count_o !== 3'd3) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 3", i, count_o); end
        end
        enq_vld_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (deq_payload_o !== 8'hDA + 8'(i)) begin errors++; $display("FAIL b2b_tail[%0d]: got %0h expected %0h", i, deq_payload_o, 8'hDA + 8'(i)); end
            tick();
        end
        deq_rdy_i = 1'b0;
    endtask

    task automatic test_flush();
        fill(8'hE0, 3);
        flush_i       = 1'b1;
        enq_vld_i     = 1'b1;
        enq_payload_i = 8'hEE;
        #1;
        checks++;
        if (enq_rdy_o !== 1'b1) begin errors++; $display("FAIL flush_rdy: got %b expected 1", enq_rdy_o); end
        tick();
        flush_i   = 1'b0;
        enq_vld_i = 1'b0;
        #1;
        checks += 3;
        if (count_o !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count_o); end
        if (deq_vld_o !== 1'b0) begin errors++; $display("FAIL flush_vld: got %b expected 0", deq_vld_o); end
        if (almost_empty_o !== 1'b1) begin errors++; $display("FAIL flush_ae: got %b expected 1", almost_empty_o); end
        fill(8'hF0, 1);
        checks += 2;
        if (count_o !== 3'd1) begin errors++; $display("FAIL flush_after_count: got %0d expected 1", count_o); end
        if (deq_payload_o !== 8'hF0) begin errors++; $display("FAIL flush_after_data: got %0h expected f0", deq_payload_o); end
        deq_rdy_i = 1'b1;
        tick();
        deq_rdy_i = 1'b0;
        checks++;
        if (deq_vld_o !== 1'b0) begin errors++; $display("FAIL flush_final_empty: got %b expected 0", deq_vld_o); end
    endtask

    task automatic test_async_reset();
        fill(8'h11, 2);
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (count_o !== 3'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", count_o); end
        if (deq_vld_o !== 1'b0) begin errors++; $display("FAIL arst_vld: got %b expected 0", deq_vld_o); end
        if (enq_rdy_o !== 1'b1) begin errors++; $display("FAIL arst_rdy: got %b expected 1", enq_rdy_o); end
        if (almost_full_o !== 1'b0) begin errors++; $display("FAIL arst_af: got %b expected 0", almost_full_o); end
        if (almost_empty_o !== 1'b1) begin errors++; $display("FAIL arst_ae: got %b expected 1", almost_empty_o); end
        #3;
        rst = 1'b0;
        tick();
        fill(8'h55, 1);
        checks += 3;
        if (deq_vld_o !== 1'b1) begin errors++; $display("FAIL arst_push_vld: got %b expected 1", deq_vld_o); end
        if (deq_payload_o !== 8'h55) begin errors++; $display("FAIL arst_push_data: got %0h expected 55", deq_payload_o); end
        if (count_o !== 3'd1) begin errors++; $display("FAIL arst_push_count: got %0d expected 1", count_o); end
        deq_rdy_i = 1'b1;
        tick();
        deq_rdy_i = 1'b0;
    endtask

    task automatic test_bypass();
        enq_vld_i     = 1'b1;
        enq_payload_i = 8'h77;
        deq_rdy_i     = 1'b1;
        #1;
`ifdef STREAM_FIFO_WM_BYPASS_EN
        checks += 2;
        if (deq_vld_o !== 1'b1) begin errors++; $display("FAIL byp_vld: got %b expected 1", deq_vld_o); end
        if (deq_payload_o !== 8'h77) begin errors++; $display("FAIL byp_data: got %0h expected 77", deq_payload_o); end
        tick();
        enq_vld_i = 1'b0;
        #1;
        checks += 2;
        if (count_o !== 3'd0) begin errors++; $display("FAIL byp_count: got %0d expected 0", count_o); end
        if (deq_vld_o !== 1'b0) begin errors++; $display("FAIL byp_after_vld: got %b expected 0", deq_vld_o); end
`else
        checks++;
        if (deq_vld_o !== 1'b0) begin errors++; $display("FAIL nobyp_vld0: got %b expected 0", deq_vld_o); end
        tick();
        enq_vld_i = 1'b0;
        #1;
        checks += 3;
        if (deq_vld_o !== 1'b1) begin errors++; $display("FAIL nobyp_vld1: got %b expected 1", deq_vld_o); end
        if (deq_payload_o !== 8'h77) begin errors++; $display("FAIL nobyp_data: got %0h expected 77", deq_payload_o); end
        if (count_o !== 3'd1) begin errors++; $display("FAIL nobyp_count: got %0d expected 1", count_o); end
        tick();
        checks++;
        if (count_o !== 3'd0) begin errors++; $display("FAIL nobyp_pop: got %0d expected 0", count_o); end
`endif
        deq_rdy_i = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        flush_i       = 1'b0;
        enq_vld_i     = 1'b0;
        enq_payload_i = '0;
        deq_rdy_i     = 1'b0;
        test_reset();
        #5;
        rst = 1'b0;
        tick();
        test_fill_drain();
        test_full_pop();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
